// File: rtl/acc_pkg.sv
// Shared accelerator constants and the result-writeback state encoding.
// One C row segment is BPR beats of DATA_W bits.
package acc_pkg;

  localparam int SIZE   = 16;
  localparam int DATA_W = 256;
  localparam int ELEM_W = 32;
  localparam int BPR    = SIZE * ELEM_W / DATA_W;

  typedef enum logic [2:0] {
    IDLE,
    ROW_REQ,
    BEATS,
    WAIT_DONE,
    SKIP,
    FINISH
  } wb_state_e;

endpackage

// File: rtl/wb_strb_gen.sv
// Byte strobes for one write beat: an element lane is enabled
// only while its column index is still inside the matrix width.
module wb_strb_gen #(
  parameter int DATA_W = acc_pkg::DATA_W,
  parameter int ELEM_W = acc_pkg::ELEM_W
) (
  input  logic [32:0]         col_base,
  input  logic [31:0]         n,
  output logic [DATA_W/8-1:0] strb
);

  localparam int EPB = DATA_W / ELEM_W;
  localparam int EB  = ELEM_W / 8;

  // 33-bit compare keeps columns near 2^32 from wrapping
  always_comb begin
    strb = '0;
    for (int e = 0; e < EPB; e++) begin
      if ((col_base + 33'(e)) < {1'b0, n}) begin
        strb[e*EB +: EB] = '1;
      end
    end
  end

endmodule

// File: rtl/result_writeback.sv
// Streams result beats of C into DMA write bursts, one burst per
// live row segment; rows past m are drained without DMA traffic.
module result_writeback #(
  parameter int SIZE   = acc_pkg::SIZE,
  parameter int DATA_W = acc_pkg::DATA_W,
  parameter int ELEM_W = acc_pkg::ELEM_W
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start,
  input  logic [31:0]         addr_base_c,
  input  logic [31:0]         m,
  input  logic [31:0]         n,
  input  logic [31:0]         row_stride,
  input  logic                res_valid,
  output logic                res_ready,
  input  logic [DATA_W-1:0]   res_data,
  output logic                dma_wr_start,
  output logic [31:0]         dma_wr_addr,
  output logic                dma_wr_valid,
  input  logic                dma_wr_ready,
  output logic [DATA_W-1:0]   dma_wr_data,
  output logic [DATA_W/8-1:0] dma_wr_strb,
  input  logic                dma_wr_done,
  output logic                busy,
  output logic                done
);

  import acc_pkg::*;

  localparam int NB  = SIZE * ELEM_W / DATA_W;
  localparam int EPB = DATA_W / ELEM_W;
  localparam int RW  = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int BW  = (NB > 1) ? $clog2(NB) : 1;

  wb_state_e   state_q, state_d;
  logic [31:0] base_q, base_d;
  logic [31:0] m_q, m_d;
  logic [31:0] n_q, n_d;
  logic [31:0] stride_q, stride_d;
  logic [31:0] m_cnt_q, m_cnt_d;
  logic [31:0] n_cnt_q, n_cnt_d;
  logic [RW-1:0] row_q, row_d;
  logic [BW-1:0] beat_q, beat_d;

  logic [32:0] row_abs;
  logic [31:0] row_addr;
  logic        last_beat;
  logic        last_row;
  logic        n_end;
  logic        m_end;

  logic [31:0]   m_adv;
  logic [31:0]   n_adv;
  logic [RW-1:0] row_adv;
  wb_state_e     st_adv;

  logic [32:0]         col_base;
  logic [DATA_W/8-1:0] strb_w;

  assign row_abs   = {1'b0, m_cnt_q} + 33'(row_q);
  assign last_beat = (beat_q == BW'(NB - 1));
  assign last_row  = (row_q == RW'(SIZE - 1));
  assign n_end     = ({1'b0, n_cnt_q} + 33'(SIZE)) >= {1'b0, n_q};
  assign m_end     = ({1'b0, m_cnt_q} + 33'(SIZE)) >= {1'b0, m_q};

  assign row_addr = base_q
                  + row_abs[31:0] * stride_q
                  + {n_cnt_q[29:0], 2'b00};

  assign col_base = {1'b0, n_cnt_q} + 33'(beat_q) * 33'(EPB);

  wb_strb_gen #(
    .DATA_W (DATA_W),
    .ELEM_W (ELEM_W)
  ) u_strb (
    .col_base (col_base),
    .n        (n_q),
    .strb     (strb_w)
  );

  // Position and state after the current row segment retires
  always_comb begin
    m_adv   = m_cnt_q;
    n_adv   = n_cnt_q;
    row_adv = row_q + RW'(1);
    st_adv  = ROW_REQ;
    if (last_row) begin
      row_adv = '0;
      if (n_end) begin
        n_adv = '0;
        if (!m_end) begin
          m_adv = m_cnt_q + 32'(SIZE);
        end
      end else begin
        n_adv = n_cnt_q + 32'(SIZE);
      end
    end
    if (last_row && n_end && m_end) begin
      st_adv = FINISH;
    end else if (({1'b0, m_adv} + 33'(row_adv)) >= {1'b0, m_q}) begin
      st_adv = SKIP;
    end
  end

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    m_d          = m_q;
    n_d          = n_q;
    stride_d     = stride_q;
    m_cnt_d      = m_cnt_q;
    n_cnt_d      = n_cnt_q;
    row_d        = row_q;
    beat_d       = beat_q;
    res_ready    = 1'b0;
    dma_wr_start = 1'b0;
    dma_wr_addr  = '0;
    dma_wr_valid = 1'b0;
    dma_wr_data  = '0;
    dma_wr_strb  = '0;
    done         = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          base_d   = addr_base_c;
          m_d      = m;
          n_d      = n;
          stride_d = row_stride;
          m_cnt_d  = '0;
          n_cnt_d  = '0;
          row_d    = '0;
          beat_d   = '0;
          state_d  = (m == '0 || n == '0) ? FINISH : ROW_REQ;
        end
      end
      ROW_REQ: begin
        dma_wr_start = 1'b1;
        dma_wr_addr  = row_addr;
        state_d      = BEATS;
      end
      BEATS: begin
        dma_wr_valid = res_valid;
        res_ready    = dma_wr_ready;
        dma_wr_data  = res_data;
        dma_wr_strb  = strb_w;
        if (res_valid && dma_wr_ready) begin
          if (last_beat) begin
            beat_d  = '0;
            state_d = WAIT_DONE;
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end
      end
      WAIT_DONE: begin
        if (dma_wr_done) begin
          m_cnt_d = m_adv;
          n_cnt_d = n_adv;
          row_d   = row_adv;
          state_d = st_adv;
        end
      end
      SKIP: begin
        res_ready = 1'b1;
        if (res_valid) begin
          if (last_beat) begin
            beat_d  = '0;
            m_cnt_d = m_adv;
            n_cnt_d = n_adv;
            row_d   = row_adv;
            state_d = st_adv;
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end
      end
      FINISH: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      base_q   <= '0;
      m_q      <= '0;
      n_q      <= '0;
      stride_q <= '0;
      m_cnt_q  <= '0;
      n_cnt_q  <= '0;
      row_q    <= '0;
      beat_q   <= '0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      m_q      <= m_d;
      n_q      <= n_d;
      stride_q <= stride_d;
      m_cnt_q  <= m_cnt_d;
      n_cnt_q  <= n_cnt_d;
      row_q    <= row_d;
      beat_q   <= beat_d;
    end
  end

endmodule

// File: tb/tb_result_writeback.sv
// Scoreboard bench for result_writeback: expected bursts and beats
// are queued from a reference walk and retired as the DUT emits them.
module tb_result_writeback;

  import acc_pkg::*;

  localparam int SW  = DATA_W / 8;
  localparam int EPB = DATA_W / ELEM_W;
  localparam int EB  = ELEM_W / 8;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              start = 1'b0;
  logic [31:0]       addr_base_c = '0;
  logic [31:0]       m = '0;
  logic [31:0]       n = '0;
  logic [31:0]       row_stride = '0;
  logic              res_valid = 1'b0;
  logic              res_ready;
  logic [DATA_W-1:0] res_data = '0;
  logic              dma_wr_start;
  logic [31:0]       dma_wr_addr;
  logic              dma_wr_valid;
  logic              dma_wr_ready = 1'b1;
  logic [DATA_W-1:0] dma_wr_data;
  logic [SW-1:0]     dma_wr_strb;
  logic              dma_wr_done = 1'b0;
  logic              busy;
  logic              done;

  result_writeback dut (
    .clk          (clk),
    .rstn         (rstn),
    .start        (start),
    .addr_base_c  (addr_base_c),
    .m            (m),
    .n            (n),
    .row_stride   (row_stride),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .dma_wr_start (dma_wr_start),
    .dma_wr_addr  (dma_wr_addr),
    .dma_wr_valid (dma_wr_valid),
    .dma_wr_ready (dma_wr_ready),
    .dma_wr_data  (dma_wr_data),
    .dma_wr_strb  (dma_wr_strb),
    .dma_wr_done  (dma_wr_done),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] d;
    logic [SW-1:0]     s;
  } beat_t;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0]       exp_addr[$];
  beat_t             exp_beat[$];
  logic [DATA_W-1:0] src[$];

  function automatic logic [DATA_W-1:0] rand_beat();
    logic [DATA_W-1:0] v;
    for (int i = 0; i < DATA_W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [SW-1:0] model_strb(longint col0, longint nn);
    logic [SW-1:0] s;
    s = '0;
    for (int e = 0; e < EPB; e++)
      if (col0 + e < nn) s[e*EB +: EB] = '1;
    return s;
  endfunction

  task automatic build(input int mm, input int nn,
                       input logic [31:0] base, input logic [31:0] stride);
    logic [DATA_W-1:0] d;
    beat_t eb;
    exp_addr.delete();
    exp_beat.delete();
    src.delete();
    for (int mt = 0; mt < mm; mt += SIZE)
      for (int nt = 0; nt < nn; nt += SIZE)
        for (int r = 0; r < SIZE; r++) begin
          if (mt + r < mm)
            exp_addr.push_back(base + 32'(mt + r) * stride + 32'(nt * 4));
          for (int b = 0; b < BPR; b++) begin
            d = rand_beat();
            src.push_back(d);
            if (mt + r < mm) begin
              eb.d = d;
              eb.s = model_strb(longint'(nt + b * EPB), longint'(nn));
              exp_beat.push_back(eb);
            end
          end
        end
  endtask

  task automatic run_job(input string name, input int mm, input int nn,
                         input logic [31:0] base, input logic [31:0] stride,
                         input bit stall, input bit poke,
                         output int bursts, output int consumed);
    int idx;
    int wbeats;
    int cd;
    bit in_burst;
    bit got_done;
    logic [31:0] ea;
    beat_t eb;
    build(mm, nn, base, stride);
    idx = 0; wbeats = 0; cd = -1; in_burst = 0; got_done = 0; bursts = 0;
    dma_wr_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; addr_base_c = base; m = mm; n = nn; row_stride = stride;
    @(posedge clk); #1;
    start = 1'b0; addr_base_c = 32'hDEAD_BEEF; m = 7; n = 3; row_stride = 32'h55;
    for (int cyc = 0; cyc < 20000 && !got_done; cyc++) begin
      @(negedge clk);
      if (dma_wr_start) begin
        bursts++;
        vectors++;
        if (exp_addr.size() == 0) begin
          miscompares++;
          $display("FAIL %s extra burst addr=%h", name, dma_wr_addr);
        end else begin
          ea = exp_addr.pop_front();
          if (dma_wr_addr !== ea) begin
            miscompares++;
            $display("FAIL %s burst %0d addr got=%h exp=%h",
                     name, bursts, dma_wr_addr, ea);
          end
        end
        wbeats = 0;
        in_burst = 1;
      end
      if (dma_wr_valid && dma_wr_ready) begin
        vectors++;
        if (exp_beat.size() == 0) begin
          miscompares++;
          $display("FAIL %s extra beat strb=%h", name, dma_wr_strb);
        end else begin
          eb = exp_beat.pop_front();
          if (dma_wr_data !== eb.d || dma_wr_strb !== eb.s) begin
            miscompares++;
            $display("FAIL %s beat strb got=%h exp=%h data got=%h exp=%h",
                     name, dma_wr_strb, eb.s, dma_wr_data, eb.d);
          end
        end
        wbeats++;
        if (wbeats == BPR) begin
          in_burst = 0;
          cd = stall ? int'($urandom_range(0, 7)) : 0;
        end
      end
      if (res_valid && res_ready) idx++;
      if (done) got_done = 1;
      @(posedge clk); #1;
      dma_wr_done = 1'b0;
      if (cd == 0) begin
        dma_wr_done = 1'b1;
        cd = -1;
      end else if (cd > 0) begin
        cd--;
      end else if (stall && in_burst && $urandom_range(0, 3) == 0) begin
        dma_wr_done = 1'b1;
      end
      res_valid = (idx < src.size()) && (!stall || $urandom_range(0, 3) != 0);
      res_data = (idx < src.size()) ? src[idx] : '0;
      dma_wr_ready = !stall || $urandom_range(0, 2) != 0;
      start = poke && (cyc == 10);
    end
    res_valid = 1'b0;
    dma_wr_done = 1'b0;
    start = 1'b0;
    dma_wr_ready = 1'b1;
    consumed = idx;
    vectors++;
    if (!got_done) begin
      miscompares++;
      $display("FAIL %s done timeout", name);
    end
    vectors++;
    if (exp_addr.size() != 0 || exp_beat.size() != 0 || idx != src.size()) begin
      miscompares++;
      $display("FAIL %s leftover addr=%0d beats=%0d consumed=%0d of %0d",
               name, exp_addr.size(), exp_beat.size(), idx, src.size());
    end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL %s idle after done busy=%b done=%b", name, busy, done);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    #3;
    vectors++;
    if ({res_ready, dma_wr_start, dma_wr_valid, dma_wr_addr, dma_wr_data,
         dma_wr_strb, busy, done} !== '0) begin
      miscompares++;
      $display("FAIL reset outputs nonzero busy=%b addr=%h strb=%h",
               busy, dma_wr_addr, dma_wr_strb);
    end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_job(input string name, input int mm, input int nn,
                          input logic [31:0] base, input logic [31:0] stride,
                          input bit stall, input bit poke,
                          input int exp_bursts, input int exp_cons);
    int b;
    int c;
    run_job(name, mm, nn, base, stride, stall, poke, b, c);
    vectors++;
    if (b != exp_bursts || c != exp_cons) begin
      miscompares++;
      $display("FAIL %s bursts got=%0d exp=%0d consumed got=%0d exp=%0d",
               name, b, exp_bursts, c, exp_cons);
    end
  endtask

  task automatic test_zero_dim(input string name, input int mm, input int nn);
    bit saw_start;
    saw_start = 0;
    @(posedge clk); #1;
    start = 1'b1; m = mm; n = nn; addr_base_c = 32'h100; row_stride = 64;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    saw_start = dma_wr_start;
    vectors++;
    if (done !== 1'b1 || saw_start) begin
      miscompares++;
      $display("FAIL %s done got=%b exp=1 start=%b", name, done, saw_start);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0 || dma_wr_start !== 1'b0) begin
      miscompares++;
      $display("FAIL %s after pulse done=%b busy=%b start=%b",
               name, done, busy, dma_wr_start);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    seen = 0;
    dma_wr_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; m = 16; n = 16; addr_base_c = 32'h6000; row_stride = 64;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (dma_wr_start) seen = 1;
    end
    vectors++;
    if (!seen || dma_wr_addr !== 32'h6000) begin
      miscompares++;
      $display("FAIL rst_mid first burst seen=%b addr=%h", seen, dma_wr_addr);
    end
    @(posedge clk); #1;
    res_valid = 1'b1; res_data = rand_beat();
    @(posedge clk); #1;
    res_data = rand_beat();
    @(posedge clk); #1;
    res_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (res_ready !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid wait_done res_ready=%b busy=%b", res_ready, busy);
    end
    res_valid = 1'b1;
    #1 rstn = 1'b0;
    #1;
    vectors++;
    if ({res_ready, dma_wr_start, dma_wr_valid, dma_wr_addr, dma_wr_data,
         dma_wr_strb, busy, done} !== '0) begin
      miscompares++;
      $display("FAIL rst_mid outputs nonzero busy=%b res_ready=%b data=%h",
               busy, res_ready, dma_wr_data);
    end
    res_valid = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid done during reset got=%b exp=0", done);
    end
    rstn = 1'b1;
    test_job("rst_clean", 16, 16, 32'h5000, 64, 0, 0, 16, 32);
  endtask

  initial begin
    test_reset();
    test_job("full_tile", 16, 16, 32'h1000, 64, 0, 0, 16, 32);
    test_job("part_cols", 16, 12, 32'h2000, 48, 0, 0, 16, 32);
    test_job("row_skip", 5, 16, 32'h3000, 64, 0, 0, 5, 32);
    test_job("zero_strb", 3, 20, 32'h4000, 80, 0, 0, 6, 64);
    test_job("addr_wrap", 2, 8, 32'hFFFF_FF00, 32'h100, 0, 0, 2, 32);
    test_job("stalls", 32, 32, 32'h8000_0000, 128, 1, 1, 64, 128);
    test_zero_dim("n_zero", 16, 0);
    test_zero_dim("m_zero", 0, 16);
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/result_writeback.md
RESULT_WRITEBACK -- requirements
Module: result_writeback

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- SIZE, 16: array tile edge in elements.
- DATA_W, 256: beat width.
- ELEM_W, 32: result element width.
REQ-002 Ports (name, direction, width, meaning) SHALL be:
- clk  in  1  single clock.
- rstn  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle job request.
- addr_base_c  in  32  byte address of C[0][0].
- m  in  32  rows of C.
- n  in  32  columns of C.
- row_stride  in  32  byte pitch between C rows.
- res_valid  in  1  result beat valid.
- res_ready  out  1  result beat accept.
- res_data  in  DATA_W  8 elements, element 0 in bits [31:0].
- dma_wr_start  out  1  one-cycle burst request.
- dma_wr_addr  out  32  burst start address.
- dma_wr_valid  out  1  write beat valid.
- dma_wr_ready  in  1  write beat accept.
- dma_wr_data  out  DATA_W  write beat.
- dma_wr_strb  out  DATA_W/8  byte strobes.
- dma_wr_done  in  1  burst complete.
- busy  out  1  job in progress.
- done  out  1  one-cycle job-complete pulse.

Function
REQ-003 One C row segment (SIZE elements) SHALL be BPR = SIZE*ELEM_W/DATA_W = 2 beats; result stream order SHALL be tile (m_cnt outer, n_cnt inner, both step SIZE), then row 0..SIZE-1, then beat 0..BPR-1.
REQ-004 On start in IDLE, addr_base_c, m, n and row_stride SHALL be latched, all counters zeroed, and busy set next cycle; start outside IDLE SHALL be ignored.
REQ-005 If latched m==0 or n==0, the block SHALL pulse done one cycle after start, with no DMA activity.
REQ-006 States SHALL be IDLE, ROW_REQ, BEATS, WAIT_DONE, SKIP and FINISH.
REQ-007 ROW_REQ SHALL apply when row r = m_cnt+row_cnt < m: pulse dma_wr_start for exactly 1 cycle, with dma_wr_addr = addr_base_c + r*row_stride + n_cnt*4 (mod 2^32), then go to BEATS.
REQ-008 When r >= m, the block SHALL enter SKIP instead of ROW_REQ.
REQ-009 In BEATS, dma_wr_valid SHALL equal res_valid, res_ready SHALL equal dma_wr_ready, and dma_wr_data SHALL equal res_data, combinationally with zero added latency; beat_cnt SHALL advance on res_valid&res_ready.
REQ-010 After beat BPR-1 transfers, BEATS SHALL go to WAIT_DONE.
REQ-011 Strobe bits [4e+3:4e] SHALL be 1 iff column n_cnt + beat_cnt*8 + e < n.
REQ-012 All-zero-strobe beats SHALL still be sent.
REQ-013 In WAIT_DONE, res_ready SHALL be 0; on dma_wr_done the block SHALL advance row/tile counters.
REQ-014 In SKIP, res_ready SHALL be 1 and dma_wr_valid 0; the BPR beats SHALL be consumed and discarded, then counters advance.
REQ-015 Row wrap SHALL go row_cnt SIZE-1 -> 0 with n_cnt += SIZE; when n_cnt+SIZE >= n, n_cnt -> 0 and m_cnt += SIZE; when m_cnt+SIZE >= m as well, the block SHALL go to FINISH.
REQ-016 FINISH SHALL pulse done for 1 cycle, clear busy, and return to IDLE.
REQ-017 dma_wr_done outside WAIT_DONE SHALL be ignored.
REQ-018 res_ready SHALL be 0 in IDLE, ROW_REQ and FINISH.
REQ-019 Offsets SHALL be compared as 33-bit unsigned so m or n near 2^32 cannot wrap the comparisons.

Reset
REQ-020 rstn low SHALL asynchronously force IDLE and clear all counters and latched registers.
REQ-021 rstn low SHALL drive every output to 0 (res_ready, dma_wr_start, dma_wr_valid, dma_wr_addr, dma_wr_data, dma_wr_strb, busy, done).
REQ-022 Reset mid-job SHALL abandon the job with no done pulse; a new start SHALL be accepted after release.

Structure
REQ-023 SIZE, DATA_W, ELEM_W, BPR and the state encoding SHALL live in shared package acc_pkg.
REQ-024 Strobe computation SHALL be sub-module wb_strb_gen (inputs col_base, n; output DATA_W/8 strobes).

Verification
REQ-025 m=16, n=16, base=0x1000, stride=64, always ready: expect 16 bursts at addresses 0x1000+64r, all strobes 0xFFFFFFFF, then done.
REQ-026 m=16, n=12, stride=48: expect beat 0 strb=0xFFFFFFFF and beat 1 strb=0x0000FFFF on every row.
REQ-027 m=5, n=16: expect 5 bursts, 11 rows skipped (22 beats consumed), no dma_wr_start for rows 5..15, then done.
REQ-028 m=32, n=32, random dma_wr_ready/res_valid stalls and dma_wr_done delayed 0-7 cycles: expect 64 bursts in tile order, data matched beat-for-beat.
REQ-029 n=0: expect done one cycle after start with no dma_wr_start; start pulsed while busy is ignored.
REQ-030 rstn asserted during WAIT_DONE: expect all outputs 0 immediately; a subsequent start runs a clean job from row 0.
